// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and default timing parameters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_e;

    localparam int SW_CLK_HZ    = 100_000_000;
    localparam int SW_SAMPLE_HZ = 1_000;
    localparam int SW_DB_DEPTH  = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, tick-sampled history, debounced level and
// a registered single-cycle press pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_DEPTH = stopwatch_pkg::SW_DB_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic press,
    output logic level
);

    logic [1:0]          r_sync;
    logic [DB_DEPTH-1:0] r_hist;
    logic                r_level;
    logic                r_level_d;
    logic                r_press;
    logic [DB_DEPTH-1:0] w_hist_nxt;

    // Level is judged on the history as it will be after this tick's shift,
    // so the level moves on the same edge that completes the run of samples.
    assign w_hist_nxt = {r_hist[DB_DEPTH-2:0], r_sync[1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_hist    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn_in};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (tick) begin
                r_hist <= w_hist_nxt;
                if (&w_hist_nxt)
                    r_level <= 1'b1;
                else if (~|w_hist_nxt)
                    r_level <= 1'b0;
            end
        end
    end

    assign press = r_press;
    assign level = r_level;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounced buttons drive a STOP/RUN/CLEAR Moore FSM with
// registered outputs. The mode button/toggle exists only with STOPWATCH_CU_MODE_EN.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = SW_CLK_HZ,
    parameter int SAMPLE_HZ = SW_SAMPLE_HZ,
    parameter int DB_DEPTH  = SW_DB_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clear,
    input  logic btn_mode,
    output logic run_stop,
    output logic clear,
    output logic mode
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_tick;
    sw_state_e     r_state;
    sw_state_e     w_state_nxt;
    logic          r_run_stop;
    logic          r_clear;
    logic          w_press_run;
    logic          w_press_clr;
    logic          w_run_lvl;
    logic          w_clr_lvl;

    assign w_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_run (
        .clk(clk), .reset(reset), .tick(w_tick), .btn_in(btn_run),
        .press(w_press_run), .level(w_run_lvl)
    );

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_clr (
        .clk(clk), .reset(reset), .tick(w_tick), .btn_in(btn_clear),
        .press(w_press_clr), .level(w_clr_lvl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_STOP;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP: begin
                if (w_press_clr)
                    w_state_nxt = ST_CLEAR;
                else if (w_press_run)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_press_run)
                    w_state_nxt = ST_STOP;
            end
            ST_CLEAR: w_state_nxt = ST_STOP;
            default:  w_state_nxt = ST_STOP;
        endcase
    end

    // run_stop gates the datapath clock, so it must come straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_stop <= 1'b0;
            r_clear    <= 1'b0;
        end else begin
            r_run_stop <= (r_state == ST_RUN);
            r_clear    <= (r_state == ST_CLEAR);
        end
    end

    assign run_stop = r_run_stop;
    assign clear    = r_clear;

`ifdef STOPWATCH_CU_MODE_EN
    logic w_press_mode;
    logic w_mode_lvl;
    logic r_mode;

    btn_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_mode (
        .clk(clk), .reset(reset), .tick(w_tick), .btn_in(btn_mode),
        .press(w_press_mode), .level(w_mode_lvl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_mode <= 1'b0;
        else if (w_press_mode)
            r_mode <= ~r_mode;
    end

    assign mode = r_mode;

    logic w_unused;
    assign w_unused = &{1'b0, w_run_lvl, w_clr_lvl, w_mode_lvl};
`else
    assign mode = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, btn_mode, w_run_lvl, w_clr_lvl};
`endif

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed self-checking bench for stopwatch_cu (tick every 10 clk, 4-deep debounce).
module tb_stopwatch_cu;

`ifdef STOPWATCH_CU_MODE_EN
    localparam bit MODE_EN = 1'b1;
`else
    localparam bit MODE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_run, btn_clear, btn_mode;
    logic run_stop, clear, mode;

    int total = 0;
    int bad   = 0;

    int run_rises  = 0;
    int clr_pulses = 0;
    int clr_len    = 0;
    int clr_max    = 0;
    logic run_prev = 1'b0;

    always #5 clk = ~clk;

    stopwatch_cu #(.CLK_HZ(1000), .SAMPLE_HZ(100), .DB_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .run_stop(run_stop), .clear(clear), .mode(mode)
    );

    // Output edge / pulse-width monitor, sampled away from the active edge.
    always @(negedge clk) begin
        run_prev <= run_stop;
        if (run_stop && !run_prev)
            run_rises <= run_rises + 1;
        if (clear) begin
            clr_len <= clr_len + 1;
        end else begin
            if (clr_len != 0) begin
                clr_pulses <= clr_pulses + 1;
                if (clr_len > clr_max)
                    clr_max <= clr_len;
            end
            clr_len <= 0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold for 60 clk, then let everything settle for 60 clk.
    task automatic press_run();
        btn_run = 1'b1; step(60); btn_run = 1'b0; step(60);
    endtask

    task automatic press_clr();
        btn_clear = 1'b1; step(60); btn_clear = 1'b0; step(60);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; step(60); btn_mode = 1'b0; step(60);
    endtask

    int lat;
    int rises0, pulses0;

    initial begin
        reset = 1'b1; btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
        step(3);
        chk("rst_run_stop", run_stop, 0);
        chk("rst_clear", clear, 0);
        chk("rst_mode", mode, 0);
        reset = 1'b0;
        step(5);

        // Clean run press: rises within 50 clk, only once while held
        btn_run = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (run_stop && lat < 0) lat = i;
        end
        btn_run = 1'b0;
        step(60);
        chk("run_latency_le50", int'(lat > 0 && lat <= 50), 1);
        chk("run_held_on", run_stop, 1);
        chk("run_single_rise", run_rises, 1);

        // Clear press while running is ignored
        pulses0 = clr_pulses;
        press_clr();
        chk("clr_in_run_pulses", clr_pulses - pulses0, 0);
        chk("clr_in_run_still_run", run_stop, 1);

        // Second run press stops
        press_run();
        chk("stop_run_stop", run_stop, 0);
        chk("stop_rises", run_rises, 1);

        // Clear from STOP: exactly one 1-clk pulse
        pulses0 = clr_pulses;
        press_clr();
        chk("clr_stop_pulses", clr_pulses - pulses0, 1);
        chk("clr_stop_width", clr_max, 1);
        chk("clr_stop_run_stop", run_stop, 0);

        // Bounce: toggle every 7 clk for 100 clk
        rises0 = run_rises;
        for (int i = 0; i < 100; i++) begin
            if (i % 7 == 0) btn_run = ~btn_run;
            step(1);
        end
        btn_run = 1'b0;
        step(80);
        chk("bounce_run_stop", run_stop, 0);
        chk("bounce_rises", run_rises - rises0, 0);

        // Simultaneous run+clear in STOP: clear wins
        rises0 = run_rises; pulses0 = clr_pulses;
        btn_run = 1'b1; btn_clear = 1'b1;
        step(60);
        btn_run = 1'b0; btn_clear = 1'b0;
        step(60);
        chk("simul_clr_pulses", clr_pulses - pulses0, 1);
        chk("simul_run_stop", run_stop, 0);
        chk("simul_rises", run_rises - rises0, 0);

        // Mode toggle
        press_mode();
        chk("mode_first", mode, MODE_EN ? 1 : 0);
        press_mode();
        chk("mode_second", mode, 0);

        // Reset mid-operation: RUN, mode set, run press half-debounced
        press_run();
        chk("pre_rst_run", run_stop, 1);
        press_mode();
        chk("pre_rst_mode", mode, MODE_EN ? 1 : 0);
        btn_run = 1'b1;
        step(25);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_run_stop", run_stop, 0);
        chk("async_rst_clear", clear, 0);
        chk("async_rst_mode", mode, 0);
        step(4);
        reset = 1'b0;
        rises0 = run_rises;
        // Ticks land on edges 10/20/30/40 after release; level, press, state,
        // output then follow on edges 40, 41, 42, 43.
        step(42);
        chk("post_rst_edge42", run_stop, 0);
        step(1);
        chk("post_rst_edge43", run_stop, 1);
        step(40);
        btn_run = 1'b0;
        step(60);
        chk("post_rst_still_run", run_stop, 1);
        chk("post_rst_one_press", run_rises - rises0, 1);
        chk("post_rst_mode", mode, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
